// File: rtl/tap_delay_line.sv
// Parametrised delay line with per-stage valid tracking and a selectable output tap.
// Latency: tap_sel enabled cycles (0 = combinational bypass); tail is DEPTH enabled cycles.
// Backpressure: en=0 holds every stage and occ in place; flush clears and overrides en.
module tap_delay_line #(
    parameter  int WIDTH        = 8,
    parameter  int DEPTH        = 5,
    parameter  int TAP_W        = 3,
    parameter  int GATE_INVALID = 0,
    localparam int OCC_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAP_W-1:0] tap_sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             tail_valid,
    output logic [WIDTH-1:0] tail_data,
    output logic [OCC_W-1:0] occ,
    output logic             full
);

    // Index k-1 holds stage k; index 0 is the stage nearest the input.
    logic [WIDTH-1:0] s_dat [DEPTH];
    logic [DEPTH-1:0] s_vld;
    logic [OCC_W-1:0] occ_q;
    logic [WIDTH-1:0] entry_dat;
    logic [TAP_W-1:0] tap_eff;

    // Optionally zero the payload of invalid words so stale data never travels down the line.
    always_comb begin
        entry_dat = in_data;
        if ((GATE_INVALID != 0) && !in_valid) begin
            entry_dat = '0;
        end
    end

    // Stage data shift register: flush clears, en advances, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                s_dat[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                s_dat[k] <= '0;
            end
        end else if (en) begin
            s_dat[0] <= entry_dat;
            for (int k = 1; k < DEPTH; k++) begin
                s_dat[k] <= s_dat[k-1];
            end
        end
    end

    // Valid bits shift alongside the data; the occupancy counter tracks their popcount.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_vld <= '0;
            occ_q <= '0;
        end else if (flush) begin
            s_vld <= '0;
            occ_q <= '0;
        end else if (en) begin
            s_vld <= {s_vld[DEPTH-2:0], in_valid};
            // When the line is full the tail word always leaves, so this cannot exceed DEPTH.
            occ_q <= occ_q + OCC_W'(in_valid) - OCC_W'(s_vld[DEPTH-1]);
        end
    end

    // Clamp out-of-range tap selects to the last stage.
    always_comb begin
        tap_eff = tap_sel;
        if (tap_sel > TAP_W'(DEPTH)) begin
            tap_eff = TAP_W'(DEPTH);
        end
    end

    // Output tap mux: tap 0 bypasses the line, tap k reads stage k.
    always_comb begin
        out_valid = in_valid;
        out_data  = in_data;
        for (int k = 1; k <= DEPTH; k++) begin
            if (tap_eff == TAP_W'(k)) begin
                out_valid = s_vld[k-1];
                out_data  = s_dat[k-1];
            end
        end
    end

    assign tail_valid = s_vld[DEPTH-1];
    assign tail_data  = s_dat[DEPTH-1];
    assign occ        = occ_q;
    assign full       = (occ_q == OCC_W'(DEPTH));

endmodule

// File: tb/tb_tap_delay_line.sv
module tb_tap_delay_line;
    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int TAP_W = 3;
    localparam int OCC_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic [TAP_W-1:0] tap_sel = '0;

    logic             u_out_valid, u_tail_valid, u_full;
    logic [WIDTH-1:0] u_out_data, u_tail_data;
    logic [OCC_W-1:0] u_occ;
    logic             g_out_valid, g_tail_valid, g_full;
    logic [WIDTH-1:0] g_out_data, g_tail_data;
    logic [OCC_W-1:0] g_occ;

    int n_tests = 0;
    int n_fail  = 0;

    tap_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAP_W(TAP_W), .GATE_INVALID(0)) u_dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .tap_sel(tap_sel), .out_valid(u_out_valid), .out_data(u_out_data),
        .tail_valid(u_tail_valid), .tail_data(u_tail_data), .occ(u_occ), .full(u_full)
    );

    tap_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAP_W(TAP_W), .GATE_INVALID(1)) g_dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .tap_sel(tap_sel), .out_valid(g_out_valid), .out_data(g_out_data),
        .tail_valid(g_tail_valid), .tail_data(g_tail_data), .occ(g_occ), .full(g_full)
    );

    always #5 clk = ~clk;

    // Reference model: history of accepted entries, most recent first.
    typedef struct packed { logic v; logic [WIDTH-1:0] d; } ent_t;
    ent_t hist[$];

    typedef struct packed {
        logic en; logic fl; logic v; logic [WIDTH-1:0] d; logic [TAP_W-1:0] tap;
        logic ev; logic [WIDTH-1:0] ed; logic [OCC_W-1:0] eocc;
    } vec_t;
    vec_t tbl [7];

    function automatic ent_t stage(input int k);
        if (k <= hist.size()) return hist[k-1];
        return '0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        int   t;
        int   cnt;
        ent_t o;
        ent_t tl;
        t = (int'(tap_sel) > DEPTH) ? DEPTH : int'(tap_sel);
        if (t == 0) o = {in_valid, in_data};
        else        o = stage(t);
        tl  = stage(DEPTH);
        cnt = 0;
        for (int k = 1; k <= DEPTH; k++) cnt += int'(stage(k).v);
        chk({tag, ".u_out_valid"}, u_out_valid, o.v);
        chk({tag, ".u_out_data"},  u_out_data,  o.d);
        chk({tag, ".g_out_valid"}, g_out_valid, o.v);
        chk({tag, ".g_out_data"},  g_out_data,  (t == 0 || o.v) ? o.d : 8'h00);
        chk({tag, ".u_tail_valid"}, u_tail_valid, tl.v);
        chk({tag, ".u_tail_data"},  u_tail_data,  tl.d);
        chk({tag, ".g_tail_data"},  g_tail_data,  tl.v ? tl.d : 8'h00);
        chk({tag, ".u_occ"}, u_occ, cnt);
        chk({tag, ".g_occ"}, g_occ, cnt);
        chk({tag, ".u_full"}, u_full, cnt == DEPTH);
    endtask

    task automatic drive(input logic e, input logic f, input logic v, input logic [WIDTH-1:0] d,
                         input logic [TAP_W-1:0] t);
        en = e; flush = f; in_valid = v; in_data = d; tap_sel = t;
        #1;
    endtask

    // Clock edge: update the model with the inputs seen at this edge, return at the negedge.
    task automatic tick();
        @(posedge clk);
        if (flush) begin
            hist.delete();
        end else if (en) begin
            hist.push_front({in_valid, in_data});
            if (hist.size() > DEPTH) void'(hist.pop_back());
        end
        @(negedge clk);
    endtask

    task automatic step(input logic e, input logic f, input logic v, input logic [WIDTH-1:0] d,
                        input logic [TAP_W-1:0] t, input string tag);
        drive(e, f, v, d, t);
        check_model(tag);
        tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".out_valid"}, u_out_valid, 0);
        chk({tag, ".out_data"},  u_out_data,  0);
        chk({tag, ".g_out_data"}, g_out_data, 0);
        chk({tag, ".tail_valid"}, u_tail_valid, 0);
        chk({tag, ".tail_data"},  u_tail_data,  0);
        chk({tag, ".occ"},  u_occ,  0);
        chk({tag, ".full"}, u_full, 0);
    endtask

    // Asynchronous reset pulse starting at a negedge; outputs must clear before any clock edge.
    task automatic mid_reset(input string tag);
        tap_sel = 3'd3;
        reset = 1'b0;
        #1;
        hist.delete();
        chk_zero(tag);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        ent_t got[$];
        int   first_idx;
        int   idx;

        tbl[0] = {1'b1, 1'b0, 1'b1, 8'd4, 3'd5, 1'b0, 8'd0, 3'd0};
        for (int i = 1; i <= 4; i++) tbl[i] = {1'b1, 1'b0, 1'b0, 8'd0, 3'd5, 1'b0, 8'd0, 3'd1};
        tbl[5] = {1'b1, 1'b0, 1'b0, 8'd0, 3'd5, 1'b1, 8'd4, 3'd1};
        tbl[6] = {1'b1, 1'b0, 1'b0, 8'd0, 3'd5, 1'b0, 8'd0, 3'd0};

        // Reset state, then bypass at tap 0 while still in reset.
        in_valid = 1'b1; in_data = 8'h33; tap_sel = 3'd5;
        #1;
        chk_zero("reset");
        tap_sel = 3'd0;
        #1;
        chk("reset.bypass_valid", u_out_valid, 1);
        chk("reset.bypass_data",  u_out_data,  8'h33);
        chk("reset.bypass_gdata", g_out_data,  8'h33);
        #10;
        reset = 1'b1;
        @(negedge clk);

        // Single valid word through 5 stages.
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].en, tbl[i].fl, tbl[i].v, tbl[i].d, tbl[i].tap);
            check_model($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.out_valid", i), u_out_valid, tbl[i].ev);
            chk($sformatf("tbl%0d.out_data", i),  u_out_data,  tbl[i].ed);
            chk($sformatf("tbl%0d.occ", i),       u_occ,       tbl[i].eocc);
            tick();
        end

        // Tap sweep over a counter stream.
        mid_reset("tap.rst");
        for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 1'b1, 8'(i), 3'(i), "tap.fill");
        for (int t = 0; t < 8; t++) begin
            drive(1'b0, 1'b0, 1'b1, 8'd7, 3'(t));
            check_model("tap.sweep");
            chk($sformatf("tap%0d.data", t), u_out_data, (t == 0) ? 7 : (t <= 5 ? 7 - t : 2));
            chk($sformatf("tap%0d.valid", t), u_out_valid, 1);
            tick();
        end

        // Stall in the middle of a stream: delay grows, order and count preserved.
        mid_reset("stall.rst");
        first_idx = -1;
        for (int i = 0; i < 14; i++) begin
            case (i)
                0:       drive(1'b1, 1'b0, 1'b1, 8'd10, 3'd5);
                1:       drive(1'b1, 1'b0, 1'b1, 8'd11, 3'd5);
                2, 3:    drive(1'b0, 1'b0, 1'b1, 8'd99, 3'd5);
                4:       drive(1'b1, 1'b0, 1'b1, 8'd12, 3'd5);
                default: drive(1'b1, 1'b0, 1'b0, 8'd0, 3'd5);
            endcase
            check_model("stall");
            if (i == 2 || i == 3) chk("stall.occ_hold", u_occ, 2);
            if (u_out_valid) begin
                got.push_back({u_out_valid, u_out_data});
                if (first_idx < 0) first_idx = i;
            end
            tick();
        end
        chk("stall.count", got.size(), 3);
        chk("stall.first_cycle", first_idx, 7);
        for (int i = 0; i < 3; i++) begin
            idx = i;
            if (idx < got.size()) chk($sformatf("stall.word%0d", i), got[idx].d, 10 + i);
        end

        // Flush after 5 valid words; the flushed-cycle input must never appear.
        mid_reset("flush.rst");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h20 + i), 3'd2, "flush.fill");
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 3'd5);
        chk("flush.full_before", u_full, 1);
        check_model("flush.cyc");
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 3'd1);
        chk("flush.occ", u_occ, 0);
        chk("flush.full", u_full, 0);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00, 3'(1 + (i % 5)));
            check_model("flush.drain");
            chk("flush.no_ff_valid", u_out_valid, 0);
            chk("flush.no_ff_data", u_out_data, 0);
            tick();
        end
        // Flush with en=0 still clears.
        step(1'b1, 1'b0, 1'b1, 8'h41, 3'd1, "flush2.fill");
        step(1'b1, 1'b0, 1'b1, 8'h42, 3'd1, "flush2.fill");
        step(1'b0, 1'b1, 1'b1, 8'hFF, 3'd1, "flush2.cyc");
        drive(1'b0, 1'b0, 1'b0, 8'h00, 3'd2);
        chk("flush2.occ", u_occ, 0);
        chk("flush2.tap2_valid", u_out_valid, 0);
        tick();

        // Invalid words with and without payload gating.
        mid_reset("gate.rst");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'hAA, 3'd5, "gate.fill");
        drive(1'b0, 1'b0, 1'b0, 8'h00, 3'd5);
        chk("gate.g_tail_data", g_tail_data, 8'h00);
        chk("gate.u_tail_data", u_tail_data, 8'hAA);
        chk("gate.u_tail_valid", u_tail_valid, 0);
        chk("gate.g_tail_valid", g_tail_valid, 0);
        tick();

        // Fill to full, keep feeding, then reset mid-stream.
        mid_reset("full.rst");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h50 + i), 3'd4, "full.fill");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'(8'h60 + i), 3'd4);
            chk("full.full", u_full, 1);
            chk("full.occ", u_occ, 5);
            check_model("full.feed");
            tick();
        end
        in_valid = 1'b1;
        mid_reset("full.midrst");
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 3'(i), "full.after");

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                mid_reset("rand.rst");
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 1'($urandom),
                     8'($urandom), 3'($urandom_range(0, 7)), "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tap_delay_line.md
Name: tap_delay_line

Overview:
- Parametrised pipeline delay line with valid tracking; successor to the fixed 8-bit, 5-stage D_FF8 chain.
- Configurable width and depth, global stall, synchronous flush, and a runtime-selectable output tap.
- Used to align activations, weights and control between CNN accelerator pipeline stages whose latencies differ or change per mode.

Parameters:
WIDTH, 8, data bits per stage
DEPTH, 5, number of register stages (>=2)
TAP_W, 3, width of tap_sel (must satisfy 2**TAP_W > DEPTH)
GATE_INVALID, 0, 1 = data of an invalid input is stored as zero

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
en  in  1  advance enable; 0 = whole line holds
flush  in  1  synchronous clear of all stages, priority over en
in_valid  in  1  input qualifier
in_data  in  WIDTH  input data
tap_sel  in  TAP_W  output delay select in cycles (0..DEPTH)
out_valid  out  1  valid at selected tap
out_data  out  WIDTH  data at selected tap
tail_valid  out  1  valid of stage DEPTH
tail_data  out  WIDTH  data of stage DEPTH
occ  out  clog2(DEPTH+1)  registered count of valid stages
full  out  1  occ == DEPTH

Behaviour:
- State: stage data s[1..DEPTH] and stage valid v[1..DEPTH]; s[1] is nearest the input.
- Reset (reset=0, asynchronous assert, synchronous release):
  - all s, v, occ = 0; full = 0; tail_* = 0.
  - out_* = 0 unless tap_sel = 0.
- Rising edge, reset=1, flush=1:
  - all s, v, occ <= 0; that cycle's input is dropped; en is ignored.
- Rising edge, flush=0, en=1:
  - s[1] <= in_data, or 0 if GATE_INVALID=1 and in_valid=0; v[1] <= in_valid.
  - s[k] <= s[k-1] and v[k] <= v[k-1] for k = 2..DEPTH; s[DEPTH]/v[DEPTH] are discarded.
- Rising edge, flush=0, en=0: all stages and occ hold; in_* are ignored.
- occ is registered and always equals popcount(v):
  - next occ = occ + in_valid - v[DEPTH] when advancing.
  - Must never exceed DEPTH or underflow; simultaneous entry and exit leaves occ unchanged.
- full = (occ == DEPTH), combinational from occ.
- Output tap mux (combinational, no added latency):
  - tap_sel = 0: out_* = in_* (bypass; zero-cycle delay).
  - tap_sel = k, 1..DEPTH: out_data = s[k], out_valid = v[k]; delay is k enabled cycles.
  - tap_sel > DEPTH: clamped to DEPTH.
- tap_sel may change any cycle; it affects only out_*, never stored state.
- tail_* always equal s[DEPTH]/v[DEPTH], independent of tap_sel.
- Latency is counted in en=1 edges; stalled cycles add delay but never duplicate or lose entries.
- Reset asserted mid-stream: immediate clear; no partial entries survive release.
- Flush and en=0 in the same cycle: flush wins.

Test Plan:
1. WIDTH=8, DEPTH=5, tap_sel=5, en=1; reset low 12 ns then high; 8'd4 valid for one cycle -> out_valid=1, out_data=4 exactly 5 edges later for one cycle; occ goes 1..1 then 0.
2. tap_sel swept 0..7 with a counter stream 1,2,3,... (all valid) -> out_data = in_data - tap_sel for 1..5; tap_sel=0 gives in_data; tap_sel 6 and 7 behave as 5.
3. Stream 10,11,12 with en=0 for 2 cycles after the second edge -> out_data at tap 5 arrives 2 cycles later, order 10,11,12 preserved, no duplicates; occ holds during the stall.
4. 5 valid words, then flush=1 with in_valid=1, data 8'hFF -> next cycle occ=0, full=0, all v=0; 8'hFF never appears at any tap.
5. GATE_INVALID=1, in_valid=0 with in_data=8'hAA -> tail_data=0 after 5 edges; with GATE_INVALID=0 -> tail_data=8'hAA and tail_valid=0.
6. Continuous valid input for 5 edges -> full=1, occ=5; keep feeding -> occ stays 5; reset pulsed low mid-stream -> all outputs 0 immediately, before the next clock edge.
